// File: rtl/cia_serial_peer.sv
// Far-end partner for the CIA SP/CNT serial port: clocks bytes into a CIA in input
// mode (dir=0) or captures bytes a CIA shifts out in output mode (dir=1).
module cia_serial_peer #(
    parameter int HALF_PERIOD = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       dir,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       busy,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out
);
    localparam int PW = $clog2(HALF_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH} tx_state_t;

    // Idle lines are high, so the synchronisers reset high to avoid a fake edge.
    logic [2:0] cnt_sync, sp_sync;
    logic       cnt_rise;
    assign cnt_rise = cnt_sync[1] & ~cnt_sync[2] & dir;

    tx_state_t     state, state_nx;
    logic [PW-1:0] ph_cnt, ph_cnt_nx;
    logic [2:0]    tx_bits, tx_bits_nx;
    logic [6:0]    tx_shift, tx_shift_nx;
    logic          sp_nx, tx_abort, ready_en, ph_end;

    logic          rise_d, dir_q;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    rx_byte;
    logic          rx_shift_en, rx_abort, rx_tmo, rx_drop, byte_done;

    assign ph_end   = (ph_cnt == PW'(HALF_PERIOD - 1));
    assign cnt_out  = (state != TX_LOW);
    assign tx_ready = ready_en & (state == TX_IDLE) & ~dir;
    assign busy     = (state != TX_IDLE) | (bit_cnt != 3'd0);

    always_comb begin
        state_nx    = state;
        ph_cnt_nx   = ph_cnt;
        tx_bits_nx  = tx_bits;
        tx_shift_nx = tx_shift;
        sp_nx       = sp_out;
        tx_abort    = 1'b0;
        case (state)
            TX_IDLE: begin
                sp_nx = 1'b1;
                if (tx_valid && tx_ready) begin
                    tx_shift_nx = tx_data[6:0];
                    tx_bits_nx  = 3'd7;
                    ph_cnt_nx   = '0;
                    sp_nx       = tx_data[7];
                    state_nx    = TX_LOW;
                end
            end
            TX_LOW: begin
                if (ph_end) begin
                    ph_cnt_nx = '0;
                    state_nx  = TX_HIGH;
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            TX_HIGH: begin
                if (ph_end) begin
                    ph_cnt_nx = '0;
                    if (tx_bits == 3'd0) begin
                        state_nx = TX_IDLE;
                        sp_nx    = 1'b1;
                    end else begin
                        tx_bits_nx  = tx_bits - 3'd1;
                        sp_nx       = tx_shift[6];
                        tx_shift_nx = {tx_shift[5:0], 1'b0};
                        state_nx    = TX_LOW;
                    end
                end else begin
                    ph_cnt_nx = ph_cnt + 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
        // Host turned the link around mid-byte: release both lines, no retry.
        if (dir && state != TX_IDLE) begin
            state_nx  = TX_IDLE;
            sp_nx     = 1'b1;
            ph_cnt_nx = '0;
            tx_abort  = 1'b1;
        end
    end

    // SP is taken from the third stage so it lines up with the CNT edge sample.
    assign rx_shift_en = rise_d & dir;
    assign rx_byte     = {rx_shift, sp_sync[2]};
    assign rx_abort    = dir_q & ~dir & (bit_cnt != 3'd0);
    assign rx_tmo      = dir & (bit_cnt != 3'd0) & ~cnt_rise & (tmo_cnt == TW'(TIMEOUT - 1));
    assign rx_drop     = rx_abort | rx_tmo;
    assign byte_done   = rx_shift_en & (bit_cnt == 3'd7) & ~rx_drop;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_sync <= '1;
            sp_sync  <= '1;
            state    <= TX_IDLE;
            ph_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            sp_out   <= 1'b1;
            ready_en <= 1'b0;
            rise_d   <= 1'b0;
            dir_q    <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tmo_cnt  <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            cnt_sync <= {cnt_sync[1:0], cnt_in};
            sp_sync  <= {sp_sync[1:0], sp_in};
            state    <= state_nx;
            ph_cnt   <= ph_cnt_nx;
            tx_bits  <= tx_bits_nx;
            tx_shift <= tx_shift_nx;
            sp_out   <= sp_nx;
            ready_en <= 1'b1;
            rise_d   <= cnt_rise;
            dir_q    <= dir;
            rx_valid <= byte_done & ~tx_abort;
            rx_error <= tx_abort | rx_drop;
            if (rx_drop) begin
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                if (rx_shift_en) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_data <= rx_byte;
                end
                if (cnt_rise || bit_cnt == 3'd0) tmo_cnt <= '0;
                else                             tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cia_serial_peer.sv
// Directed bench for cia_serial_peer: transmit waveform, receive path, timeout,
// turnaround aborts and asynchronous reset.
module tb_cia_serial_peer;
    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_error, busy;
    logic       cnt_in = 1'b1;
    logic       sp_in = 1'b1;
    logic       cnt_out, sp_out;

    int n_chk = 0;
    int n_err = 0;

    int         n_valid = 0;
    int         n_errp = 0;
    int         n_both = 0;
    logic [7:0] rx_log [0:63];

    always #5 clk = ~clk;

    cia_serial_peer #(.HALF_PERIOD(4), .TIMEOUT(4096)) dut (
        .clk(clk), .res_n(res_n), .dir(dir),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .busy(busy),
        .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .sp_out(sp_out)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            if (n_valid < 64) rx_log[n_valid] <= rx_data;
            n_valid <= n_valid + 1;
        end
        if (rx_error) n_errp <= n_errp + 1;
        if (rx_valid && rx_error) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CIA output-mode model: CNT low phase, then CNT rises together with the new SP bit.
    task automatic cia_send(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cnt_in = 1'b0;
            repeat (4) @(negedge clk);
            cnt_in = 1'b1;
            sp_in  = b[7-i];
            repeat (4) @(negedge clk);
        end
    endtask

    logic [63:0] cnt_pat, sp_pat, exp_cnt, exp_sp;
    logic [7:0]  pat;
    int          rdy_hi, low_run, hi_run, rises, bad, v0, e0;
    logic        prev;

    initial begin
        // reset values
        @(negedge clk);
        check("rst_cnt_out", cnt_out, 1'b1);
        check("rst_sp_out", sp_out, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_error", rx_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        res_n = 1'b1;
        @(negedge clk);
        check("rel_tx_ready", tx_ready, 1'b1);

        // transmit A5: 8 CNT pulses, 4 clk low / 4 clk high, MSB first
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rdy_hi = 0;
        pat = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            cnt_pat[i] = cnt_out;
            sp_pat[i]  = sp_out;
            exp_cnt[i] = ((i % 8) >= 4);
            exp_sp[i]  = pat[7 - i/8];
            if (tx_ready) rdy_hi++;
            @(negedge clk);
        end
        check("t1_cnt_wave", cnt_pat, exp_cnt);
        check("t1_sp_wave", sp_pat, exp_sp);
        check("t1_ready_low", rdy_hi, 0);
        check("t1_end_ready", tx_ready, 1'b1);
        check("t1_end_sp", sp_out, 1'b1);
        check("t1_end_cnt", cnt_out, 1'b1);
        check("t1_end_busy", busy, 1'b0);

        // tx_valid held with 00: one idle clk between bytes
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        low_run = 0; hi_run = 0;
        for (int i = 0; i < 200 && !tx_ready; i++) begin low_run++; @(negedge clk); end
        for (int i = 0; i < 200 && tx_ready; i++) begin hi_run++; @(negedge clk); end
        check("b2b_busy_clks", low_run, 64);
        check("b2b_idle_clks", hi_run, 1);
        check("b2b_cnt_low", cnt_out, 1'b0);
        check("b2b_sp_zero", sp_out, 1'b0);
        tx_valid = 1'b0;
        repeat (70) @(negedge clk);

        // transmit FF, turn the link around after the 3rd CNT rise
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        e0 = n_errp;
        rises = 0; prev = cnt_out;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(negedge clk);
            if (cnt_out && !prev) rises++;
            prev = cnt_out;
        end
        check("t4_rises", rises, 3);
        dir = 1'b1;
        @(negedge clk);
        check("t4_cnt_out", cnt_out, 1'b1);
        check("t4_sp_out", sp_out, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_err_pulse", rx_error, 1'b1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_ready || !cnt_out || !sp_out) bad++;
        end
        check("t4_hold_idle", bad, 0);
        check("t4_err_count", n_errp - e0, 1);

        // receive 3C then C3 back-to-back
        v0 = n_valid; e0 = n_errp;
        cia_send(8'h3C, 8);
        cia_send(8'hC3, 8);
        repeat (8) @(negedge clk);
        check("t2_valid_count", n_valid - v0, 2);
        check("t2_byte0", rx_log[v0], 8'h3C);
        check("t2_byte1", rx_log[v0+1], 8'hC3);
        check("t2_no_error", n_errp - e0, 0);
        check("t2_rx_data", rx_data, 8'hC3);

        // 5 bits then silence: timeout drops the partial byte
        v0 = n_valid; e0 = n_errp;
        cia_send(8'hA8, 5);
        check("t3_busy", busy, 1'b1);
        repeat (4000) @(negedge clk);
        check("t3_no_early_err", n_errp - e0, 0);
        repeat (300) @(negedge clk);
        check("t3_one_err", n_errp - e0, 1);
        check("t3_no_valid", n_valid - v0, 0);
        check("t3_busy_clear", busy, 1'b0);
        check("t3_data_kept", rx_data, 8'hC3);
        cia_send(8'h81, 8);
        repeat (8) @(negedge clk);
        check("t3_next_count", n_valid - v0, 1);
        check("t3_next_byte", rx_log[v0], 8'h81);

        // partial byte, then dir 1->0
        v0 = n_valid; e0 = n_errp;
        cia_send(8'hE0, 3);
        dir = 1'b0;
        @(negedge clk);
        check("dirab_err_pulse", rx_error, 1'b1);
        check("dirab_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        check("dirab_err_count", n_errp - e0, 1);
        check("dirab_no_valid", n_valid - v0, 0);

        // external CNT toggling while transmitting direction is selected
        v0 = n_valid; e0 = n_errp;
        cia_send(8'h55, 8);
        repeat (10) @(negedge clk);
        check("t5_no_valid", n_valid - v0, 0);
        check("t5_no_error", n_errp - e0, 0);
        check("t5_busy", busy, 1'b0);

        // asynchronous reset in TX_LOW
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t6_in_low", cnt_out, 1'b0);
        check("t6_sp_low", sp_out, 1'b0);
        #2 res_n = 1'b0;
        #1;
        check("t6_rst_cnt", cnt_out, 1'b1);
        check("t6_rst_sp", sp_out, 1'b1);
        check("t6_rst_ready", tx_ready, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        res_n = 1'b1;
        #1;
        check("t6_ready_wait", tx_ready, 1'b0);
        @(negedge clk);
        check("t6_ready_after", tx_ready, 1'b1);

        check("never_both", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
